// File: rtl/opcode_sequencer_pkg.sv
// opcode_sequencer_pkg: opcode constants, sequencer state type and opcode-pair
// helpers shared by the opcode sequencer and its bus interface.
// Build option: OPSEQ_INTR_EN adds the interrupt-insertion states.
package opcode_sequencer_pkg;

  localparam int unsigned OPCODE_W = 5;

  typedef logic [OPCODE_W-1:0] opcode_t;

  localparam opcode_t OP_NOP   = 5'b00000;
  localparam opcode_t OP_CALL  = 5'b11000;
  localparam opcode_t OP_CALL2 = 5'b11001;
  localparam opcode_t OP_RET   = 5'b11010;
  localparam opcode_t OP_RET2  = 5'b11011;
  localparam opcode_t OP_RTI   = 5'b11100;
  localparam opcode_t OP_RTI2  = 5'b11101;
  localparam opcode_t OP_INT1  = 5'b11110;
  localparam opcode_t OP_INT2  = 5'b11111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALL2 = 3'd1,
    S_RET2  = 3'd2,
    S_RTI2  = 3'd3
`ifdef OPSEQ_INTR_EN
    ,
    S_INT1  = 3'd4,
    S_INT2  = 3'd5
`endif
  } seq_state_e;

  // Second half of a two-part opcode pair; NOP for anything else.
  function automatic opcode_t second_part(input opcode_t first);
    case (first)
      OP_CALL: return OP_CALL2;
      OP_RET:  return OP_RET2;
      OP_RTI:  return OP_RTI2;
      OP_INT1: return OP_INT2;
      default: return OP_NOP;
    endcase
  endfunction

  // Fetched opcodes that start a two-cycle expansion.
  function automatic logic is_two_part(input opcode_t op);
    return (op == OP_CALL) || (op == OP_RET) || (op == OP_RTI);
  endfunction

  // Opcodes only the sequencer itself may generate.
  function automatic logic is_reserved(input opcode_t op);
    return (op == OP_CALL2) || (op == OP_RET2) || (op == OP_RTI2) ||
           (op == OP_INT1)  || (op == OP_INT2);
  endfunction

  // State that emits the second half after a first-part opcode.
  function automatic seq_state_e pair_state(input opcode_t first);
    case (first)
      OP_CALL: return S_CALL2;
      OP_RET:  return S_RET2;
      OP_RTI:  return S_RTI2;
      default: return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/opcode_sequencer_if.sv
// opcode_sequencer_if: fetch-side and decode-side signals of the opcode
// sequencer. master = fetch/pipeline control side, slave = sequencer.
interface opcode_sequencer_if
  import opcode_sequencer_pkg::*;
#(
  parameter int unsigned OPW = OPCODE_W
) ();

  logic           fetch_valid;
  logic [OPW-1:0] fetch_opcode;
  logic           intr_req;
  logic           stall;
  logic           flush;

  logic [OPW-1:0] dec_opcode;
  logic           dec_valid;
  logic           fetch_hold;
  logic           intr_ack;
  logic           illegal_op;

  modport master (
    output fetch_valid, fetch_opcode, intr_req, stall, flush,
    input  dec_opcode, dec_valid, fetch_hold, intr_ack, illegal_op
  );

  modport slave (
    input  fetch_valid, fetch_opcode, intr_req, stall, flush,
    output dec_opcode, dec_valid, fetch_hold, intr_ack, illegal_op
  );

endinterface

// File: rtl/opcode_sequencer.sv
// opcode_sequencer: produces the registered opcode stream for decode.
// Single-part opcodes pass through with one cycle of latency, CALL/RET/RTI
// expand into their opcode pair, reserved fetched opcodes become NOP with an
// illegal_op pulse, and fetch is held while opcodes are inserted.
// Build option: OPSEQ_INTR_EN adds interrupt-pair insertion at instruction
// boundaries; without it intr_req is ignored and intr_ack reads 0.
module opcode_sequencer
  import opcode_sequencer_pkg::*;
#(
  parameter int unsigned OPW = OPCODE_W
) (
  input logic               clk,
  input logic               reset_n,
  opcode_sequencer_if.slave bus
);

  seq_state_e     state_q, state_d;
  logic [OPW-1:0] dec_opcode_q, dec_opcode_d;
  logic           dec_valid_q, dec_valid_d;
  logic           illegal_op_q, illegal_op_d;
  logic           advance;

`ifdef OPSEQ_INTR_EN
  logic           intr_ack_q, intr_ack_d;
  logic           pending_q, pending_d;
  logic           int1_emit;
`else
  logic           unused_intr_req;
  assign unused_intr_req = bus.intr_req;
`endif

  // flush overrides stall, so the sequencer moves whenever either allows it.
  assign advance = ~bus.stall | bus.flush;

  // Next-state and next-output selection, defaults hold everything.
  always_comb begin
    state_d      = state_q;
    dec_opcode_d = dec_opcode_q;
    dec_valid_d  = dec_valid_q;
    illegal_op_d = illegal_op_q;
`ifdef OPSEQ_INTR_EN
    intr_ack_d   = intr_ack_q;
    int1_emit    = 1'b0;
`endif
    if (advance) begin
      state_d      = S_IDLE;
      dec_opcode_d = OP_NOP;
      dec_valid_d  = 1'b0;
      illegal_op_d = 1'b0;
`ifdef OPSEQ_INTR_EN
      intr_ack_d   = 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          // A flush discards the wrong-path opcode and leaves NOP.
          if (!bus.flush) begin
`ifdef OPSEQ_INTR_EN
            if (pending_q) begin
              dec_opcode_d = OP_INT1;
              dec_valid_d  = 1'b1;
              intr_ack_d   = 1'b1;
              int1_emit    = 1'b1;
              state_d      = S_INT2;
            end else
`endif
            if (bus.fetch_valid) begin
              if (is_two_part(bus.fetch_opcode)) begin
                dec_opcode_d = bus.fetch_opcode;
                dec_valid_d  = 1'b1;
                state_d      = pair_state(bus.fetch_opcode);
              end else if (is_reserved(bus.fetch_opcode)) begin
                illegal_op_d = 1'b1;
              end else begin
                dec_opcode_d = bus.fetch_opcode;
                dec_valid_d  = 1'b1;
              end
            end
          end
        end
        S_CALL2, S_RET2, S_RTI2: begin
          // dec_opcode_q still holds the first half: it was emitted on entry
          // and a stall only holds it, so it selects the second half.
          if (!bus.flush) begin
            dec_opcode_d = second_part(dec_opcode_q);
            dec_valid_d  = 1'b1;
          end
        end
`ifdef OPSEQ_INTR_EN
        S_INT2: begin
          // The interrupt pair is never split, so flush is ignored here.
          dec_opcode_d = OP_INT2;
          dec_valid_d  = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  // Sequencer state and registered decode outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      dec_opcode_q <= '0;
      dec_valid_q  <= 1'b0;
      illegal_op_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dec_opcode_q <= dec_opcode_d;
      dec_valid_q  <= dec_valid_d;
      illegal_op_q <= illegal_op_d;
    end
  end

`ifdef OPSEQ_INTR_EN
  // Pending request: a new request in the same cycle beats the INT1 clear.
  always_comb begin
    pending_d = pending_q;
    if (int1_emit) begin
      pending_d = 1'b0;
    end
    if (bus.intr_req) begin
      pending_d = 1'b1;
    end
  end

  // Pending flag and interrupt acknowledge registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q  <= 1'b0;
      intr_ack_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      intr_ack_q <= intr_ack_d;
    end
  end

  assign bus.intr_ack   = intr_ack_q;
  assign bus.fetch_hold = bus.stall | (state_q != S_IDLE) | (pending_q & ~bus.flush);
`else
  assign bus.intr_ack   = 1'b0;
  assign bus.fetch_hold = bus.stall | (state_q != S_IDLE);
`endif

  assign bus.dec_opcode = dec_opcode_q;
  assign bus.dec_valid  = dec_valid_q;
  assign bus.illegal_op = illegal_op_q;

endmodule

// File: tb/tb_opcode_sequencer.sv
// tb_opcode_sequencer: directed bench for opcode_sequencer with a behavioural
// model (queue of follow-on opcodes plus a pending flag) checked every cycle,
// and literal expectations for the key scenarios. Interrupt expectations
// follow OPSEQ_INTR_EN.
module tb_opcode_sequencer;

`ifdef OPSEQ_INTR_EN
  localparam bit INTR_EN = 1'b1;
`else
  localparam bit INTR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  opcode_sequencer_if #(.OPW(5)) bus ();

  opcode_sequencer #(.OPW(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model state: last emitted outputs, pending interrupt, opcodes still owed.
  logic [4:0] m_op;
  logic       m_valid, m_ack, m_ill, m_pend;
  logic [4:0] m_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit first_half(input logic [4:0] op);
    return op == 5'b11000 || op == 5'b11010 || op == 5'b11100;
  endfunction

  function automatic bit reserved_op(input logic [4:0] op);
    return op[4:3] == 2'b11 && !first_half(op);
  endfunction

  task automatic model_reset();
    m_op = 5'd0; m_valid = 1'b0; m_ack = 1'b0; m_ill = 1'b0; m_pend = 1'b0;
    m_q.delete();
  endtask

  task automatic model_step();
    logic [4:0] f, fo;
    logic np;
    fo = bus.fetch_opcode;
    np = m_pend | (INTR_EN & bus.intr_req);
    if (!bus.stall || bus.flush) begin
      m_op = 5'd0; m_valid = 1'b0; m_ack = 1'b0; m_ill = 1'b0;
      if (m_q.size() != 0) begin
        f = m_q.pop_front();
        if (f == 5'b11111 || !bus.flush) begin
          m_op = f; m_valid = 1'b1;
        end
      end else if (bus.flush) begin
        m_op = 5'd0;
      end else if (m_pend) begin
        m_op = 5'b11110; m_valid = 1'b1; m_ack = 1'b1;
        m_q.push_back(5'b11111);
        np = INTR_EN & bus.intr_req;
      end else if (bus.fetch_valid) begin
        if (first_half(fo)) begin
          m_op = fo; m_valid = 1'b1;
          m_q.push_back(fo + 5'd1);
        end else if (reserved_op(fo)) begin
          m_ill = 1'b1;
        end else begin
          m_op = fo; m_valid = 1'b1;
        end
      end
    end
    m_pend = np;
  endtask

  task automatic drive(input logic fv, input logic [4:0] op, input logic ir,
                       input logic st, input logic fl);
    bus.fetch_valid  = fv;
    bus.fetch_opcode = op;
    bus.intr_req     = ir;
    bus.stall        = st;
    bus.flush        = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step();
    #1;
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("dec_opcode", {27'd0, bus.dec_opcode}, {27'd0, m_op});
      check("dec_valid", {31'd0, bus.dec_valid}, {31'd0, m_valid});
      check("intr_ack", {31'd0, bus.intr_ack}, {31'd0, m_ack});
      check("illegal_op", {31'd0, bus.illegal_op}, {31'd0, m_ill});
      check("fetch_hold", {31'd0, bus.fetch_hold},
            {31'd0, bus.stall | (m_q.size() != 0) | (m_pend & ~bus.flush)});
    end
  end

  initial begin
    reset_n = 1'b0;
    drive(0, 5'd0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_dec_opcode", {27'd0, bus.dec_opcode}, 32'h0);
    check("rst_dec_valid", {31'd0, bus.dec_valid}, 32'h0);
    check("rst_fetch_hold", {31'd0, bus.fetch_hold}, 32'h0);
    reset_n = 1'b1;

    // Pass-through stream.
    drive(1, 5'b01001, 0, 0, 0); #1;
    check("t1_hold", {31'd0, bus.fetch_hold}, 32'h0);
    tick();
    check("t1_op0", {27'd0, bus.dec_opcode}, 32'h09);
    check("t1_val0", {31'd0, bus.dec_valid}, 32'h1);
    drive(1, 5'b00011, 0, 0, 0); tick();
    check("t1_op1", {27'd0, bus.dec_opcode}, 32'h03);

    // CALL expansion, next opcode held until cycle 3.
    drive(1, 5'b11000, 0, 0, 0); tick();
    check("call_op0", {27'd0, bus.dec_opcode}, 32'h18);
    drive(1, 5'b00101, 0, 0, 0); #1;
    check("call_hold", {31'd0, bus.fetch_hold}, 32'h1);
    tick();
    check("call_op1", {27'd0, bus.dec_opcode}, 32'h19);
    check("call_val1", {31'd0, bus.dec_valid}, 32'h1);
    tick();
    check("call_next", {27'd0, bus.dec_opcode}, 32'h05);

    // Interrupt request, then 01010 waits behind the interrupt pair.
    drive(0, 5'd0, 1, 0, 0); tick();
    drive(1, 5'b01010, 0, 0, 0); #1;
    check("int_hold", {31'd0, bus.fetch_hold}, {31'd0, INTR_EN});
    tick();
    check("int_op0", {27'd0, bus.dec_opcode}, INTR_EN ? 32'h1e : 32'h0a);
    check("int_ack", {31'd0, bus.intr_ack}, {31'd0, INTR_EN});
    tick();
    check("int_op1", {27'd0, bus.dec_opcode}, INTR_EN ? 32'h1f : 32'h0a);
    tick();
    check("int_op2", {27'd0, bus.dec_opcode}, 32'h0a);
    check("int_ack2", {31'd0, bus.intr_ack}, 32'h0);

    // RET aborted by flush in its second cycle.
    drive(1, 5'b11010, 0, 0, 0); tick();
    drive(1, 5'b00001, 0, 0, 1); tick();
    check("ret_flush_op", {27'd0, bus.dec_opcode}, 32'h0);
    check("ret_flush_val", {31'd0, bus.dec_valid}, 32'h0);
    drive(1, 5'b00001, 0, 0, 0); tick();
    check("ret_after", {27'd0, bus.dec_opcode}, 32'h01);

    // Flush during INT2 does not split the pair.
    drive(0, 5'd0, 1, 0, 0); tick();
    drive(0, 5'd0, 0, 0, 0); tick();
    drive(0, 5'd0, 0, 0, 1); tick();
    check("int2_flush_op", {27'd0, bus.dec_opcode}, INTR_EN ? 32'h1f : 32'h0);
    check("int2_flush_val", {31'd0, bus.dec_valid}, {31'd0, INTR_EN});
    drive(0, 5'd0, 0, 0, 0); tick();

    // Reserved opcodes become NOP with a one-cycle illegal_op pulse.
    drive(1, 5'b11101, 0, 0, 0); tick();
    check("ill_op", {27'd0, bus.dec_opcode}, 32'h0);
    check("ill_val", {31'd0, bus.dec_valid}, 32'h0);
    check("ill_pulse", {31'd0, bus.illegal_op}, 32'h1);
    drive(1, 5'b00010, 0, 0, 0); tick();
    check("ill_clear", {31'd0, bus.illegal_op}, 32'h0);
    check("ill_next", {27'd0, bus.dec_opcode}, 32'h02);
    drive(1, 5'b11110, 0, 0, 0); tick();
    check("ill_int1", {31'd0, bus.illegal_op}, 32'h1);
    drive(1, 5'b11111, 0, 1, 0); tick();
    check("ill_stall_hold", {31'd0, bus.illegal_op}, 32'h1);
    drive(0, 5'd0, 0, 0, 0); tick();

    // Stall inside and after a CALL pair.
    drive(1, 5'b11000, 0, 0, 0); tick();
    drive(1, 5'b00111, 0, 1, 0); tick(); tick();
    check("stall_call2", {27'd0, bus.dec_opcode}, 32'h18);
    drive(1, 5'b00111, 0, 0, 0); tick();
    check("stall_rel", {27'd0, bus.dec_opcode}, 32'h19);
    drive(1, 5'b00111, 0, 1, 0); tick();
    check("stall_hold_c2", {27'd0, bus.dec_opcode}, 32'h19);
    drive(1, 5'b00111, 0, 0, 0); tick();
    check("stall_next", {27'd0, bus.dec_opcode}, 32'h07);

    // Stall with flush in RTI2: flush wins.
    drive(1, 5'b11100, 0, 0, 0); tick();
    drive(1, 5'b00100, 0, 1, 1); tick();
    check("stfl_op", {27'd0, bus.dec_opcode}, 32'h0);

    // Request raised during stall is still taken afterwards.
    drive(0, 5'd0, 1, 1, 0); tick();
    drive(0, 5'd0, 0, 1, 0); tick();
    drive(1, 5'b00100, 0, 0, 0); tick();
    check("stall_int", {27'd0, bus.dec_opcode}, INTR_EN ? 32'h1e : 32'h04);
    tick(); tick();

    // Asynchronous reset during INT2, with a re-arming request present.
    drive(0, 5'd0, 1, 0, 0); tick();
    drive(1, 5'b00110, 0, 0, 0); tick();
    drive(1, 5'b00110, 1, 0, 0);
    #2;
    reset_n = 1'b0;
    drive(1, 5'b00110, 0, 0, 0);
    model_reset();
    #1;
    check("arst_op", {27'd0, bus.dec_opcode}, 32'h0);
    check("arst_val", {31'd0, bus.dec_valid}, 32'h0);
    check("arst_ack", {31'd0, bus.intr_ack}, 32'h0);
    check("arst_hold", {31'd0, bus.fetch_hold}, 32'h0);
    tick();
    reset_n = 1'b1;
    #1;
    check("arst_rel_hold", {31'd0, bus.fetch_hold}, 32'h0);
    tick();
    check("arst_rel_op", {27'd0, bus.dec_opcode}, 32'h06);
    check("arst_rel_ack", {31'd0, bus.intr_ack}, 32'h0);

    // Mixed traffic checked by the model alone.
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 7) == 0));
      tick();
    end

    drive(0, 5'd0, 0, 0, 0);
    tick(); tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/opcode_sequencer.md
# opcode_sequencer

Sits between fetch and the decode control unit and produces the 5-bit opcode stream that decode consumes. It passes single-part instructions through with one registered cycle of latency. For CALL, RET and RTI it expands the instruction into its two-part opcode pair, and for an external interrupt it inserts the interrupt pair at an instruction boundary. While it inserts opcodes it freezes fetch, and it filters out fetched opcodes that are reserved for sequencer-only use.

## Interface
Parameters:
- OPW, 5, opcode width; fixed to the decode opcode width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_valid  in  1  fetch_opcode holds a valid fetched instruction.
- fetch_opcode  in  OPW  opcode of the fetched instruction.
- intr_req  in  1  external interrupt request (level); sampled every cycle.
- stall  in  1  downstream hazard stall; hold all state.
- flush  in  1  taken branch in execute; discard the wrong-path opcode.
- dec_opcode  out  OPW  registered opcode presented to decode.
- dec_valid  out  1  dec_opcode is a real (non-bubble) opcode.
- fetch_hold  out  1  combinational; high when fetch_opcode is not consumed this cycle, so fetch must hold PC and instruction.
- intr_ack  out  1  registered one-cycle pulse, coincident with dec_opcode = 11110.
- illegal_op  out  1  registered one-cycle pulse when a reserved fetched opcode is replaced by NOP.

## Operation
- Opcode pairs: CALL 11000→11001; RET 11010→11011; RTI 11100→11101; interrupt 11110→11111; NOP is 00000.
- State machine states: IDLE, CALL2, RET2, RTI2, INT1, INT2.
- IDLE, highest priority first:
  - flush: emit NOP with dec_valid=0; the interrupt stays pending.
  - interrupt pending: emit 11110, pulse intr_ack, clear pending, go to INT2. fetch_opcode is not consumed.
  - fetch_valid with opcode 11000, 11010 or 11100: emit it and go to CALL2, RET2 or RTI2 respectively.
  - fetch_valid with reserved opcode 11001, 11011, 11101, 11110 or 11111: emit NOP with dec_valid=0 and pulse illegal_op.
  - fetch_valid with any other opcode: emit it with dec_valid=1.
  - otherwise: emit NOP with dec_valid=0.
- CALL2, RET2, RTI2: emit the second-part opcode with dec_valid=1, then go to IDLE. If flush is high in this cycle, emit NOP with dec_valid=0 instead and go to IDLE; the sequence is aborted.
- INT2: emit 11111 with dec_valid=1, then go to IDLE. flush is ignored in INT2; the interrupt sequence is never split.
- fetch_hold = stall | (state ≠ IDLE) | (state = IDLE & pending & ~flush).
- Pending flag: set when intr_req=1, including during stall. Cleared only on INT1 emission; a set in the same cycle wins. Requests arriving during INT2 re-arm the flag for the next boundary.

## Timing
- Latency: an opcode consumed at edge N appears on dec_opcode after edge N, i.e. 1 cycle.
- A two-part instruction occupies decode for 2 consecutive cycles; fetch_hold is high in the second.
- An interrupt takes 2 inserted cycles; the held fetch instruction is emitted in the 3rd cycle.
- stall=1: dec_opcode, dec_valid, state and the pulses hold; intr_ack and illegal_op are not re-pulsed.
- flush and stall together: flush wins, and the state updates as if stall were low.
- Reset (asynchronous, also mid-sequence): dec_opcode=00000, dec_valid=0, state=IDLE, pending=0, intr_ack=0, illegal_op=0. fetch_hold therefore reads 0 while reset is held with stall low.

## Configuration
- OPSEQ_INTR_EN defined: interrupt logic is present as described above.
- OPSEQ_INTR_EN undefined:
  - INT1/INT2 states and the pending flag are removed; intr_req is ignored and intr_ack is tied to 0.
  - Fetched 11110/11111 are still illegal (NOP plus illegal_op).

## Structure
- Shared package: OP_NOP, OP_CALL, OP_CALL2, OP_RET, OP_RET2, OP_RTI, OP_RTI2, OP_INT1, OP_INT2 constants; the state enum; a pure function mapping a first-part opcode to its second part.
- No sub-module; this is a single FSM module.

## Test plan
- Stream 01001, 00011 with fetch_valid=1 → dec_opcode 01001 then 00011, each one cycle later, dec_valid=1, fetch_hold=0.
- fetch 11000 → dec_opcode 11000 then 11001; fetch_hold=1 in the second cycle; the next fetched opcode follows in cycle 3.
- intr_req pulse while 01010 is fetched → 11110 with intr_ack=1, then 11111, then 01010; fetch_hold=1 for 2 cycles.
- fetch 11010, then flush in the RET2 cycle → NOP with dec_valid=0, state returns to IDLE; flush during INT2 → 11111 still emitted.
- fetch 11101 → NOP with dec_valid=0 and illegal_op=1 for one cycle; stall mid-CALL2 holds 11001 and the state unchanged.
- Assert reset_n low during INT2 → all outputs reset immediately; after release, the first fetched opcode passes normally and no interrupt is pending.
